histogram_peak_finder: RTL and testbench



---
 rtl/histogram_pkg.sv | 27 ++
 rtl/hist_peak_accum.sv | 86 ++++++++
 rtl/histogram_peak_finder.sv | 172 +++++++++++++++++
 tb/tb_histogram_peak_finder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/histogram_pkg.sv
// Shared types and width helpers for the histogram unit and its peak finder.
`timescale 1ns/1ps
package histogram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } hist_state_e;

  localparam int unsigned HistSize      = 7;
  localparam int unsigned HistMaxNumber = 127;

  function automatic int unsigned hist_addr_w(input int unsigned max_number);
    return $clog2(max_number);
  endfunction

  function automatic int unsigned hist_tot_w(input int unsigned size,
                                             input int unsigned max_number);
    return size + hist_addr_w(max_number);
  endfunction

  localparam int unsigned HistAddrW = hist_addr_w(HistMaxNumber);

  typedef logic [HistAddrW-1:0] hist_bin_addr_t;

endpackage

// File: rtl/hist_peak_accum.sv
// Running peak/total accumulator for the histogram peak finder.
// Optional non-zero bin counter enabled by HIST_NONZERO_COUNT_EN.
`timescale 1ns/1ps
module hist_peak_accum #(
  parameter int unsigned SIZE   = 7,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned TOT_W  = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [SIZE-1:0]   data_i,
  // Next-state values: include the word accumulated on the coming edge.
  output logic [ADDR_W-1:0] peak_bin_nxt_o,
  output logic [SIZE-1:0]   peak_cnt_nxt_o,
  output logic [TOT_W-1:0]  total_nxt_o
`ifdef HIST_NONZERO_COUNT_EN
  ,
  output logic [ADDR_W:0]   nz_nxt_o
`endif
);

  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [SIZE-1:0]   peak_cnt_q, peak_cnt_d;
  logic [TOT_W-1:0]  total_q, total_d;
`ifdef HIST_NONZERO_COUNT_EN
  logic [ADDR_W:0]   nz_q, nz_d;
`endif

  always_comb begin
    peak_bin_d = peak_bin_q;
    peak_cnt_d = peak_cnt_q;
    total_d    = total_q;
`ifdef HIST_NONZERO_COUNT_EN
    nz_d       = nz_q;
`endif
    if (clr_i) begin
      peak_bin_d = '0;
      peak_cnt_d = '0;
      total_d    = '0;
`ifdef HIST_NONZERO_COUNT_EN
      nz_d       = '0;
`endif
    end else if (vld_i) begin
      total_d = total_q + TOT_W'(data_i);
      // Strict compare over ascending addresses keeps the lowest index on ties.
      if (data_i > peak_cnt_q) begin
        peak_cnt_d = data_i;
        peak_bin_d = idx_i;
      end
`ifdef HIST_NONZERO_COUNT_EN
      if (data_i != '0) begin
        nz_d = nz_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_bin_q <= '0;
      peak_cnt_q <= '0;
      total_q    <= '0;
`ifdef HIST_NONZERO_COUNT_EN
      nz_q       <= '0;
`endif
    end else begin
      peak_bin_q <= peak_bin_d;
      peak_cnt_q <= peak_cnt_d;
      total_q    <= total_d;
`ifdef HIST_NONZERO_COUNT_EN
      nz_q       <= nz_d;
`endif
    end
  end

  assign peak_bin_nxt_o = peak_bin_d;
  assign peak_cnt_nxt_o = peak_cnt_d;
  assign total_nxt_o    = total_d;
`ifdef HIST_NONZERO_COUNT_EN
  assign nz_nxt_o       = nz_d;
`endif

endmodule

// File: rtl/histogram_peak_finder.sv
// Scans all histogram bins on START and reports peak bin, peak count and total.
// Define HIST_NONZERO_COUNT_EN to add the nz_bins output.
`timescale 1ns/1ps
module histogram_peak_finder
  import histogram_pkg::*;
#(
  parameter int unsigned SIZE       = HistSize,
  parameter int unsigned MAX_NUMBER = HistMaxNumber,
  localparam int unsigned ADDR_W    = hist_addr_w(MAX_NUMBER),
  localparam int unsigned TOT_W     = hist_tot_w(SIZE, MAX_NUMBER)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [SIZE-1:0]   mem_out,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [SIZE-1:0]   peak_cnt,
  output logic [TOT_W-1:0]  total
`ifdef HIST_NONZERO_COUNT_EN
  ,
  output logic [ADDR_W:0]   nz_bins
`endif
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_NUMBER);

  hist_state_e state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
  logic [SIZE-1:0]   peak_cnt_q, peak_cnt_d;
  logic [TOT_W-1:0]  total_q, total_d;
  // mem_out qualifier and the address it belongs to, one cycle behind the read.
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clr;
  logic              load;

  logic [ADDR_W-1:0] acc_bin;
  logic [SIZE-1:0]   acc_cnt;
  logic [TOT_W-1:0]  acc_total;
`ifdef HIST_NONZERO_COUNT_EN
  logic [ADDR_W:0]   acc_nz;
  logic [ADDR_W:0]   nz_q, nz_d;
`endif

  always_comb begin
    state_d   = state_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clr       = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d   = StRead;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          busy_d    = 1'b1;
          clr       = 1'b1;
        end
      end
      StRead: begin
        if (rd_addr_q == LastAddr) begin
          rd_en_d = 1'b0;
          state_d = StDrain;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      StDrain: begin
        load    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign vld_d = rd_en_q;
  assign idx_d = rd_addr_q;

  always_comb begin
    peak_bin_d = peak_bin_q;
    peak_cnt_d = peak_cnt_q;
    total_d    = total_q;
`ifdef HIST_NONZERO_COUNT_EN
    nz_d       = nz_q;
`endif
    if (load) begin
      peak_bin_d = acc_bin;
      peak_cnt_d = acc_cnt;
      total_d    = acc_total;
`ifdef HIST_NONZERO_COUNT_EN
      nz_d       = acc_nz;
`endif
    end
  end

  hist_peak_accum #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W),
    .TOT_W  (TOT_W)
  ) u_accum (
    .clk_i          (CLK),
    .rst_ni         (RST),
    .clr_i          (clr),
    .vld_i          (vld_q),
    .idx_i          (idx_q),
    .data_i         (mem_out),
    .peak_bin_nxt_o (acc_bin),
    .peak_cnt_nxt_o (acc_cnt),
    .total_nxt_o    (acc_total)
`ifdef HIST_NONZERO_COUNT_EN
    ,
    .nz_nxt_o       (acc_nz)
`endif
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      peak_bin_q <= '0;
      peak_cnt_q <= '0;
      total_q    <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
`ifdef HIST_NONZERO_COUNT_EN
      nz_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      peak_bin_q <= peak_bin_d;
      peak_cnt_q <= peak_cnt_d;
      total_q    <= total_d;
      vld_q      <= vld_d;
      idx_q      <= idx_d;
`ifdef HIST_NONZERO_COUNT_EN
      nz_q       <= nz_d;
`endif
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign peak_bin = peak_bin_q;
  assign peak_cnt = peak_cnt_q;
  assign total    = total_q;
`ifdef HIST_NONZERO_COUNT_EN
  assign nz_bins  = nz_q;
`endif

endmodule

// File: tb/tb_histogram_peak_finder.sv
// Scoreboard bench for histogram_peak_finder with a 1-cycle-latency memory model.
`timescale 1ns/1ps
module tb_histogram_peak_finder;
  import histogram_pkg::*;

  localparam int unsigned Size  = 7;
  localparam int unsigned NBins = 128;
  localparam int unsigned AddrW = 7;
  localparam int unsigned TotW  = 14;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             START = 1'b0;
  logic             rd_en;
  logic [AddrW-1:0] rd_addr;
  logic [Size-1:0]  mem_out = '0;
  logic             BUSY;
  logic             DONE;
  logic [AddrW-1:0] peak_bin;
  logic [Size-1:0]  peak_cnt;
  logic [TotW-1:0]  total;
`ifdef HIST_NONZERO_COUNT_EN
  logic [AddrW:0]   nz_bins;
`endif

  histogram_peak_finder #(
    .SIZE       (Size),
    .MAX_NUMBER (NBins - 1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .mem_out  (mem_out),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .peak_bin (peak_bin),
    .peak_cnt (peak_cnt),
    .total    (total)
`ifdef HIST_NONZERO_COUNT_EN
    ,
    .nz_bins  (nz_bins)
`endif
  );

  always #5 CLK = ~CLK;

  logic [Size-1:0] mem [NBins];

  always @(posedge CLK) begin
    if (rd_en) mem_out <= mem[rd_addr];
  end

  typedef struct {
    hist_bin_addr_t  bin;
    logic [Size-1:0] cnt;
    logic [TotW-1:0] tot;
    logic [AddrW:0]  nz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.bin = '0;
    e.cnt = '0;
    e.tot = '0;
    e.nz  = '0;
    for (int i = 0; i < NBins; i++) begin
      if (mem[i] > e.cnt) begin
        e.cnt = mem[i];
        e.bin = hist_bin_addr_t'(i);
      end
      e.tot = e.tot + TotW'(mem[i]);
      if (mem[i] != '0) e.nz = e.nz + 1'b1;
    end
    return e;
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < NBins; i++) mem[i] = Size'(v);
  endtask

  task automatic compare_results(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_peak_bin"}, 32'(peak_bin), 32'(e.bin));
      check_eq({tag, "_peak_cnt"}, 32'(peak_cnt), 32'(e.cnt));
      check_eq({tag, "_total"}, 32'(total), 32'(e.tot));
`ifdef HIST_NONZERO_COUNT_EN
      check_eq({tag, "_nz_bins"}, 32'(nz_bins), 32'(e.nz));
`endif
    end
  endtask

  // extra_start_at / rst_at are edge offsets after the START edge (0 = unused).
  task automatic scan(input string tag, input int extra_start_at, input int rst_at);
    int rd_seen;
    int dones;
    int done_at;
    int last;
    rd_seen = 0;
    dones   = 0;
    done_at = 0;
    last    = (rst_at != 0) ? rst_at : 135;
    if (rst_at == 0) sb.push_back(model());
    @(negedge CLK);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(BUSY), 32'd1);
    rd_seen += int'(rd_en);
    for (int n = 1; n <= last; n++) begin
      if (n == extra_start_at) START = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      rd_seen += int'(rd_en);
      if (n == 64) check_eq({tag, "_busy_mid"}, 32'(BUSY), 32'd1);
      if (DONE) begin
        dones++;
        done_at = n;
        check_eq({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
        compare_results(tag);
      end
    end
    if (rst_at != 0) begin
      RST = 1'b0;
      #1;
      check_eq({tag, "_rst_busy"}, 32'(BUSY), 32'd0);
      check_eq({tag, "_rst_rd_en"}, 32'(rd_en), 32'd0);
      check_eq({tag, "_rst_peak_bin"}, 32'(peak_bin), 32'd0);
      check_eq({tag, "_rst_peak_cnt"}, 32'(peak_cnt), 32'd0);
      check_eq({tag, "_rst_total"}, 32'(total), 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (80) begin
        @(posedge CLK);
        #1;
        if (DONE) dones++;
      end
      check_eq({tag, "_no_done"}, 32'(dones), 32'd0);
    end else begin
      check_eq({tag, "_done_count"}, 32'(dones), 32'd1);
      check_eq({tag, "_done_latency"}, 32'(done_at), 32'd129);
      check_eq({tag, "_rd_en_cycles"}, 32'(rd_seen), 32'd128);
      check_eq({tag, "_busy_after"}, 32'(BUSY), 32'd0);
    end
  endtask

  initial begin
    fill(0);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_rd_en", 32'(rd_en), 32'd0);
    check_eq("reset_rd_addr", 32'(rd_addr), 32'd0);
    check_eq("reset_busy", 32'(BUSY), 32'd0);
    check_eq("reset_done", 32'(DONE), 32'd0);
    check_eq("reset_peak_bin", 32'(peak_bin), 32'd0);
    check_eq("reset_peak_cnt", 32'(peak_cnt), 32'd0);
    check_eq("reset_total", 32'(total), 32'd0);
`ifdef HIST_NONZERO_COUNT_EN
    check_eq("reset_nz_bins", 32'(nz_bins), 32'd0);
`endif
    @(negedge CLK);
    RST = 1'b1;

    fill(0);
    scan("zero", 0, 0);

    fill(1);
    mem[37] = 7'd100;
    scan("bin37", 0, 0);

    fill(0);
    mem[5]  = 7'd127;
    mem[90] = 7'd127;
    scan("tie", 0, 0);

    fill(127);
    scan("full_restart", 40, 0);

    for (int i = 0; i < NBins; i++) mem[i] = Size'($urandom_range(0, 127));
    scan("rand", 0, 0);

    scan("abort", 0, 60);

    fill(0);
    mem[10] = 7'd9;
    scan("after_abort", 0, 0);

    fill(0);
    mem[3]   = 7'd2;
    mem[64]  = 7'd2;
    mem[127] = 7'd2;
    scan("nz", 0, 0);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
